// File: rtl/alu_issue_ctrl.sv
// Issue controller for the ALU request/ready handshake: latches one decoded op, pulses
// dat_ready, waits for ALU_ready (with watchdog) and returns a valid/ready response.
// Optional performance counters are enabled with `define ALU_ISSUE_PERF_EN.
module alu_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int BR_OP_LO       = 4,
   parameter int BR_OP_HI       = 9
) (
   input  logic        soc_clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [4:0]  req_rd,
   output logic [31:0] ALU_dat1,
   output logic [31:0] ALU_dat2,
   output logic [5:0]  Instruction_from_CU,
   output logic        dat_ready,
   input  logic        ALU_ready,
   input  logic [31:0] ALU_out,
   input  logic        ALU_zero,
   input  logic        ALU_overflow,
   input  logic        ALU_con_met,
   input  logic        ALU_err,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [4:0]  rsp_rd,
   output logic        rsp_zero,
   output logic        rsp_ovf,
   output logic        rsp_br_taken,
   output logic        rsp_err,
   output logic        rsp_timeout
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0] perf_issued,
   output logic [15:0] perf_timeouts,
   output logic [7:0]  perf_max_lat
`endif
);

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, WAIT, RESP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state;
   logic [4:0] tag;
   logic [7:0] cnt;

   function automatic logic is_branch(input logic [5:0] op);
      return (int'(op) >= BR_OP_LO) && (int'(op) <= BR_OP_HI);
   endfunction

`ifdef ALU_ISSUE_PERF_EN
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == '1) ? v : v + 16'd1;
   endfunction
`endif

   assign req_ready = (state == IDLE);

   always_ff @(posedge soc_clk) begin
      if (reset) begin
         state               <= IDLE;
         tag                 <= '0;
         cnt                 <= '0;
         ALU_dat1            <= '0;
         ALU_dat2            <= '0;
         Instruction_from_CU <= '0;
         dat_ready           <= 1'b0;
         rsp_valid           <= 1'b0;
         rsp_result          <= '0;
         rsp_rd              <= '0;
         rsp_zero            <= 1'b0;
         rsp_ovf             <= 1'b0;
         rsp_br_taken        <= 1'b0;
         rsp_err             <= 1'b0;
         rsp_timeout         <= 1'b0;
`ifdef ALU_ISSUE_PERF_EN
         perf_issued         <= '0;
         perf_timeouts       <= '0;
         perf_max_lat        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  ALU_dat1            <= req_a;
                  ALU_dat2            <= req_b;
                  Instruction_from_CU <= req_op;
                  tag                 <= req_rd;
                  state               <= SETUP;
               end
            end
            SETUP: begin
               dat_ready <= 1'b1;
               state     <= PULSE;
`ifdef ALU_ISSUE_PERF_EN
               perf_issued <= sat_inc32(perf_issued);
`endif
            end
            PULSE: begin
               dat_ready <= 1'b0;
               cnt       <= '0;
               state     <= WAIT;
            end
            // A response arriving on the watchdog's last cycle takes priority over the timeout.
            WAIT: begin
               if (ALU_ready || (cnt == CNT_LAST)) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rd    <= tag;
`ifdef ALU_ISSUE_PERF_EN
                  if (cnt > perf_max_lat) perf_max_lat <= cnt;
`endif
                  if (ALU_ready) begin
                     rsp_result   <= ALU_out;
                     rsp_zero     <= ALU_zero;
                     rsp_ovf      <= ALU_overflow;
                     rsp_br_taken <= ALU_con_met && is_branch(Instruction_from_CU);
                     rsp_err      <= ALU_err;
                     rsp_timeout  <= 1'b0;
                  end else begin
                     rsp_result   <= '0;
                     rsp_zero     <= 1'b0;
                     rsp_ovf      <= 1'b0;
                     rsp_br_taken <= 1'b0;
                     rsp_err      <= 1'b1;
                     rsp_timeout  <= 1'b1;
`ifdef ALU_ISSUE_PERF_EN
                     perf_timeouts <= sat_inc16(perf_timeouts);
`endif
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
